// File: rtl/run_checker.sv
`timescale 1ns/1ps
// End-of-run checker: watches the fetch address for end-of-text under a cycle budget,
// then sweeps data memory against the golden answer memory and reports a verdict.
module run_checker #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 41,
  parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int MAX_CYCLES = 1000,
  parameter int ERR_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] eof_addr,
  input  logic [ADDR_W-1:0] mem_addr_I,
  output logic              rd_en,
  output logic [IDX_W-1:0]  rd_idx,
  input  logic [DATA_W-1:0] act_data,
  input  logic [DATA_W-1:0] exp_data,
  output logic              err_valid,
  output logic [IDX_W-1:0]  err_idx,
  output logic [DATA_W-1:0] err_act,
  output logic [DATA_W-1:0] err_exp,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [31:0]       cycle_cnt,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_SWEEP, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ADDR_W-1:0]  r_eof;
  logic [31:0]        r_cycle_cnt;
  logic [ERR_W-1:0]   r_err_cnt;
  logic               r_timeout;
  logic [IDX_W-1:0]   r_idx;
  logic               r_vld_p1;
  logic [IDX_W-1:0]   r_idx_p1;

  logic w_arm;
  logic w_eof_hit;
  logic w_budget_out;
  logic w_tmo;
  logic w_last;
  logic w_mismatch;

  assign w_arm        = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_eof_hit    = (r_state == S_RUN) && (mem_addr_I == r_eof);
  assign w_budget_out = (r_state == S_RUN) && (r_cycle_cnt == 32'(MAX_CYCLES - 1));
  // End-of-text takes priority over an expiring budget in the same cycle.
  assign w_tmo        = w_budget_out && !w_eof_hit;
  assign w_last       = (r_idx == IDX_W'(DEPTH - 1));
  // The compare result is suppressed while reset is asserted so no stale pulse escapes.
  assign w_mismatch   = r_vld_p1 && !rst && (act_data != exp_data);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_RUN;
      S_RUN: begin
        if (w_eof_hit)         w_next = S_SWEEP;
        else if (w_budget_out) w_next = S_DONE;
      end
      S_SWEEP: if (w_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en     = (r_state == S_SWEEP);
    busy      = (r_state == S_RUN) || (r_state == S_SWEEP) || (r_state == S_DRAIN);
    done      = (r_state == S_DONE);
    err_valid = w_mismatch;
    err_idx   = w_mismatch ? r_idx_p1 : '0;
    err_act   = w_mismatch ? act_data : '0;
    err_exp   = w_mismatch ? exp_data : '0;
    pass      = (r_state == S_DONE) && !r_timeout && (r_err_cnt == '0);
  end

  assign rd_idx    = r_idx;
  assign err_cnt   = r_err_cnt;
  assign cycle_cnt = r_cycle_cnt;
  assign timeout   = r_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt <= '0;
      r_err_cnt   <= '0;
      r_timeout   <= 1'b0;
      r_idx       <= '0;
      r_vld_p1    <= 1'b0;
    end else begin
      r_vld_p1 <= (r_state == S_SWEEP);
      if (w_arm) begin
        r_cycle_cnt <= '0;
        r_err_cnt   <= '0;
        r_timeout   <= 1'b0;
        r_idx       <= '0;
      end else begin
        // The cycle that expires the budget is not counted, leaving MAX_CYCLES-1.
        if ((r_state == S_RUN) && !w_tmo) r_cycle_cnt <= r_cycle_cnt + 32'd1;
        if (w_tmo) r_timeout <= 1'b1;
        if ((r_state == S_SWEEP) && !w_last) r_idx <= r_idx + IDX_W'(1);
        if (w_mismatch && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
    end
  end

  // Stage p1: index of the word whose read data arrives this cycle
  always_ff @(posedge clk) begin
    r_idx_p1 <= r_idx;
    if (w_arm) r_eof <= eof_addr;
  end

endmodule

// File: tb/tb_run_checker.sv
`timescale 1ns/1ps
// Directed bench for run_checker: scenario table on a default instance plus
// saturating-counter (ERR_W=2) and single-word (DEPTH=1) instances sharing the stimulus.
module tb_run_checker;
  localparam int DEPTH = 41;
  localparam int MAXC  = 1000;
  localparam logic [31:0] EOF = 32'h0000_8000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [31:0] eof_addr, mem_addr_I;

  logic        rd_en, err_valid, busy, done, pass, timeout;
  logic [5:0]  rd_idx, err_idx;
  logic [31:0] act_data, exp_data, err_act, err_exp, cycle_cnt;
  logic [7:0]  err_cnt;

  logic        s_rd_en, s_err_valid, s_busy, s_done, s_pass, s_timeout;
  logic [5:0]  s_rd_idx, s_err_idx;
  logic [31:0] s_act, s_exp, s_err_act, s_err_exp, s_cycle_cnt;
  logic [1:0]  s_err_cnt;

  logic        o_rd_en, o_err_valid, o_busy, o_done, o_pass, o_timeout;
  logic [0:0]  o_rd_idx, o_err_idx;
  logic [31:0] o_act, o_exp, o_err_act, o_err_exp, o_cycle_cnt;
  logic [7:0]  o_err_cnt;

  run_checker u_dut (
    .clk(clk), .rst(rst), .start(start), .eof_addr(eof_addr), .mem_addr_I(mem_addr_I),
    .rd_en(rd_en), .rd_idx(rd_idx), .act_data(act_data), .exp_data(exp_data),
    .err_valid(err_valid), .err_idx(err_idx), .err_act(err_act), .err_exp(err_exp),
    .err_cnt(err_cnt), .cycle_cnt(cycle_cnt), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout));

  run_checker #(.ERR_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start), .eof_addr(eof_addr), .mem_addr_I(mem_addr_I),
    .rd_en(s_rd_en), .rd_idx(s_rd_idx), .act_data(s_act), .exp_data(s_exp),
    .err_valid(s_err_valid), .err_idx(s_err_idx), .err_act(s_err_act), .err_exp(s_err_exp),
    .err_cnt(s_err_cnt), .cycle_cnt(s_cycle_cnt), .busy(s_busy), .done(s_done),
    .pass(s_pass), .timeout(s_timeout));

  run_checker #(.DEPTH(1)) u_one (
    .clk(clk), .rst(rst), .start(start), .eof_addr(eof_addr), .mem_addr_I(mem_addr_I),
    .rd_en(o_rd_en), .rd_idx(o_rd_idx), .act_data(o_act), .exp_data(o_exp),
    .err_valid(o_err_valid), .err_idx(o_err_idx), .err_act(o_err_act), .err_exp(o_err_exp),
    .err_cnt(o_err_cnt), .cycle_cnt(o_cycle_cnt), .busy(o_busy), .done(o_done),
    .pass(o_pass), .timeout(o_timeout));

  // Synchronous-read memory models
  logic [31:0] act_mem [DEPTH];
  logic [31:0] exp_mem [DEPTH];
  always @(posedge clk) begin
    if (rd_en) begin
      act_data <= act_mem[rd_idx];
      exp_data <= exp_mem[rd_idx];
    end
    if (s_rd_en) begin
      s_act <= {26'd0, s_rd_idx};
      s_exp <= ~{26'd0, s_rd_idx};
    end
    if (o_rd_en) begin
      o_act <= 32'h0000_00A5 + {31'd0, o_rd_idx};
      o_exp <= 32'h0000_00A4;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int hit_at;     // RUN cycle (1-based) showing eof; 0 = never
    int bad0;
    int bad1;
    int exp_errs;
    bit exp_pass;
    bit exp_timeout;
  } vec_t;

  vec_t vecs[5];

  task automatic fill_mem(input int bad0, input int bad1);
    for (int i = 0; i < DEPTH; i++) begin
      act_mem[i] = 32'h1000 + i * 7;
      exp_mem[i] = 32'h1000 + i * 7;
      if (i == bad0 || i == bad1) begin
        act_mem[i] = 32'h0000_0005;
        exp_mem[i] = 32'h0000_0006;
      end
    end
  endtask

  task automatic run_row(input string tag, input vec_t v);
    int lat, o_lat, rd_cnt, pulses, s_pulses, o_pulses, exp_lat;
    bit seq_ok, prev_en;
    logic [5:0] prev_idx;
    int exp_q[$];
    if (v.bad0 >= 0) exp_q.push_back(v.bad0);
    if (v.bad1 >= 0) exp_q.push_back(v.bad1);
    fill_mem(v.bad0, v.bad1);
    start = 1'b1; eof_addr = EOF; mem_addr_I = 32'h100;
    step;
    start = 1'b0;
    chk({tag, " busy after start"}, busy, 1);
    lat = -1; o_lat = -1; rd_cnt = 0; pulses = 0; s_pulses = 0; o_pulses = 0;
    seq_ok = 1'b1; prev_en = 1'b0; prev_idx = '0;
    for (int n = 0; n < 1200 && lat < 0; n++) begin
      // eof stays on the bus after the hit; it must be ignored outside RUN
      mem_addr_I = (v.hit_at > 0 && n >= v.hit_at - 1) ? EOF : 32'h100 + n * 4;
      step;
      if (rd_en) begin
        if (rd_idx != 6'(rd_cnt)) seq_ok = 1'b0;
        rd_cnt++;
      end
      if (err_valid) begin
        pulses++;
        if (pulses <= exp_q.size()) begin
          chk($sformatf("%s err_idx #%0d", tag, pulses), err_idx, exp_q[pulses-1]);
          chk($sformatf("%s err_act #%0d", tag, pulses), err_act, 32'h5);
          chk($sformatf("%s err_exp #%0d", tag, pulses), err_exp, 32'h6);
          chk($sformatf("%s err timing #%0d", tag, pulses), {prev_en, prev_idx}, {1'b1, err_idx});
        end
      end
      if (s_err_valid) s_pulses++;
      if (o_err_valid) o_pulses++;
      if (o_done && o_lat < 0) o_lat = n + 1;
      if (done) lat = n + 1;
      prev_en = rd_en; prev_idx = rd_idx;
    end
    exp_lat = (v.hit_at > 0) ? v.hit_at + DEPTH + 1 : MAXC;
    chk({tag, " done latency"}, lat, exp_lat);
    chk({tag, " pass"}, pass, v.exp_pass);
    chk({tag, " timeout"}, timeout, v.exp_timeout);
    chk({tag, " err_cnt"}, err_cnt, v.exp_errs);
    chk({tag, " err pulses"}, pulses, v.exp_errs);
    chk({tag, " rd_en count"}, rd_cnt, (v.hit_at > 0) ? DEPTH : 0);
    chk({tag, " rd_idx sequence"}, seq_ok, 1);
    if (v.exp_timeout) chk({tag, " cycle_cnt"}, cycle_cnt, MAXC - 1);
    chk({tag, " sat pulses"}, s_pulses, (v.hit_at > 0) ? DEPTH : 0);
    chk({tag, " sat err_cnt"}, s_err_cnt, (v.hit_at > 0) ? 3 : 0);
    chk({tag, " one latency"}, o_lat, (v.hit_at > 0) ? v.hit_at + 2 : MAXC);
    chk({tag, " one err_cnt"}, o_err_cnt, (v.hit_at > 0) ? 1 : 0);
    chk({tag, " one pulses"}, o_pulses, (v.hit_at > 0) ? 1 : 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    bit reached;
    vecs[0] = '{20, -1, -1, 0, 1'b1, 1'b0};
    vecs[1] = '{20,  3, 40, 2, 1'b0, 1'b0};
    vecs[2] = '{0,  -1, -1, 0, 1'b0, 1'b1};
    vecs[3] = '{1000, -1, -1, 0, 1'b1, 1'b0};
    vecs[4] = '{1,   0, -1, 1, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; eof_addr = '0; mem_addr_I = '0;
    fill_mem(-1, -1);
    step; step;
    chk("reset main ctrl", {rd_en, busy, done, pass, timeout, err_valid}, 0);
    chk("reset main rd_idx", rd_idx, 0);
    chk("reset main err_cnt", err_cnt, 0);
    chk("reset main cycle_cnt", cycle_cnt, 0);
    chk("reset main err data", {err_idx, err_act, err_exp} == '0, 1);
    chk("reset sat all", |{s_rd_en, s_rd_idx, s_err_valid, s_err_idx, s_err_act, s_err_exp,
                           s_err_cnt, s_cycle_cnt, s_busy, s_done, s_pass, s_timeout}, 0);
    chk("reset one all", |{o_rd_en, o_rd_idx, o_err_valid, o_err_idx, o_err_act, o_err_exp,
                           o_err_cnt, o_cycle_cnt, o_busy, o_done, o_pass, o_timeout}, 0);
    rst = 1'b0;
    step;
    chk("idle stays idle", {busy, done}, 0);

    for (int r = 0; r < 5; r++) run_row($sformatf("row%0d", r), vecs[r]);

    // Mid-sweep reset with a mismatch in flight, and start ignored during SWEEP
    fill_mem(9, -1);
    start = 1'b1; eof_addr = EOF; mem_addr_I = 32'h100;
    step;
    start = 1'b0; mem_addr_I = EOF;
    reached = 1'b0; k = 0;
    while (!reached && k < 100) begin
      step; k++;
      start = (rd_en && rd_idx == 6'd5);
      if (rd_en && rd_idx == 6'd10) reached = 1'b1;
    end
    start = 1'b0;
    chk("rst seq reach idx10", reached, 1);
    chk("rst seq pulse before reset", {err_valid, err_idx}, {1'b1, 6'd9});
    rst = 1'b1;
    #1;
    chk("rst seq no pulse in reset cycle", err_valid, 0);
    step;
    chk("rst seq outputs zero", |{rd_en, rd_idx, err_valid, err_idx, err_act, err_exp,
                                  err_cnt, cycle_cnt, busy, done, pass, timeout}, 0);
    rst = 1'b0;
    step;
    run_row("fresh", '{5, 9, -1, 1, 1'b0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
